tdes_result_buffer: RTL and testbench
=====================================

Name: tdes_result_buffer

Overview:
- Output-side buffer between the Triple-DES datapath and the AHB-Lite slave read path.
- Captures each completed 64-bit chunk, with its encrypt/decrypt tag, when the datapath finishes it, and holds it until the bus master reads it out.
- Lets the master send several chunks before it starts reading.
- In-order, show-ahead FIFO with occupancy count, flush and sticky error flags.

Parameters:
- DEPTH, 8, number of 64-bit result entries; power of two, range 2..32.
- DATA_W, 64, chunk width in bits; fixed by the DES block size.

Ports:
- HCLK  in  1  system clock; all logic on the rising edge.
- HRESET  in  1  synchronous reset, active-high.
- in_valid  in  1  datapath presents a completed chunk this cycle.
- in_data  in  DATA_W  completed chunk.
- in_encdec  in  1  mode tag of the chunk: 1 = encrypted, 0 = decrypted.
- in_ready  out  1  buffer can accept a chunk; equals !full.
- rd_pop  in  1  AHB slave consumes the head entry this cycle.
- rd_data  out  DATA_W  head chunk; 0 when empty.
- rd_encdec  out  1  head mode tag; 0 when empty.
- rd_valid  out  1  buffer non-empty.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- flush  in  1  discard all entries.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop hit an empty buffer.

Behaviour:
- Reset, when HRESET=1 at a rising edge:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - overflow = 0, underflow = 0.
  - rd_valid = 0, rd_data = 0, rd_encdec = 0, in_ready = 1.
  - Storage contents are don't-care.
- Reset mid-operation discards everything. It takes priority over flush, push and pop in the same cycle.
- Storage: DEPTH x (DATA_W+1) register array, holding {encdec, data}.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full and empty are derived from count, not from pointer compare.
- Push = in_valid & (!full | rd_pop):
  - writes {in_encdec, in_data} at wr_ptr, then wr_ptr++.
  - The value is visible on rd_data the next cycle if the buffer was empty.
- Pop = rd_pop & !empty: rd_ptr++.
- Show-ahead read: rd_data and rd_encdec are combinational from mem[rd_ptr], gated to 0 when empty.
- Latency:
  - Write to visible head: 1 cycle.
  - Pop to next entry visible: 1 cycle.
- Count update: count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged and moves both pointers.
- Full with push and pop together: accepted; count stays DEPTH. in_ready still reads 0, because in_ready = !full only.
- Full with push and no pop: chunk dropped, pointers and count unchanged, overflow set to 1.
- Empty with pop, with or without push:
  - pop ignored and underflow set to 1.
  - A simultaneous push still writes, and count becomes 1.
- Flush (synchronous, no reset active):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = underflow = 0.
  - Any push or pop in the same cycle is ignored.
- overflow and underflow stay set until reset or flush.
- No state machine beyond the pointer/count registers. All outputs except rd_data and rd_encdec are registered or derived directly from registered count.

Decomposition:
- tdes_pkg holds:
  - localparam DES_BLOCK_W = 64.
  - typedef logic [63:0] des_chunk_t.
  - typedef struct packed { logic encdec; des_chunk_t data; } tdes_result_t.
  - Enc/dec encoding constants ENC_MODE = 1'b1, DEC_MODE = 1'b0, shared with the AHB slave and the core.
- No sub-module: storage and control together fit in one module, about 150 lines.

Test Plan:
- Reset, then push 64'h8fe0d9c6b3674857 with tag 0 -> next cycle rd_valid=1, rd_data=64'h8fe0d9c6b3674857, rd_encdec=0, count=1. Pop -> rd_valid=0, rd_data=0, count=0.
- Order and wrap-around:
  - Push 8 distinct chunks 64'h1..64'h8 -> count=8, in_ready=0.
  - Pop 3, push 64'h9..64'hB, then pop all.
  - Required read order: 4,5,6,7,8,9,A,B; count ends at 0; no error flags.
- Full buffer, push without pop -> push dropped, overflow=1, count=8, head unchanged.
- Full buffer, push and pop in the same cycle -> count stays 8, newest chunk read out last.
- Empty buffer, pop -> underflow=1. Pop and push of 64'h0ec42b5c22a87f17 in the same cycle -> count=1, that value on rd_data next cycle.
- With 5 entries and overflow=1, assert flush -> count=0, rd_valid=0, overflow=0.
- With 5 entries and overflow=1, assert HRESET together with push and pop -> all outputs at reset values next cycle, in_ready=1.

Source files
------------

// File: rtl/tdes_pkg.sv
// Shared Triple-DES types and constants used by the core, the result buffer
// and the AHB-Lite slave.
package tdes_pkg;

  // DES operates on 64-bit blocks; every chunk moved around the core is one block.
  localparam int DES_BLOCK_W = 64;

  typedef logic [63:0] des_chunk_t;

  // One completed result: the chunk plus the mode it was produced in.
  typedef struct packed {
    logic       encdec;
    des_chunk_t data;
  } tdes_result_t;

  // Mode tag encoding, common to the AHB slave, the core and the buffer.
  localparam logic ENC_MODE = 1'b1;
  localparam logic DEC_MODE = 1'b0;

  // Build a result entry from a raw chunk and its mode tag.
  function automatic tdes_result_t packResult(input logic encdec, input des_chunk_t data);
    tdes_result_t res;
    res.encdec = encdec;
    res.data   = data;
    return res;
  endfunction

endpackage : tdes_pkg

// File: rtl/tdes_result_buffer.sv
// Output-side result buffer between the Triple-DES datapath and the AHB-Lite
// read path. In-order, show-ahead FIFO of {encdec, chunk} entries with an
// occupancy count, a synchronous flush and sticky overflow/underflow flags.
// Full/empty come from the occupancy count, so pointers may simply wrap.
module tdes_result_buffer
  import tdes_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = DES_BLOCK_W
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_encdec,
  output logic                       in_ready,
  input  logic                       rd_pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_encdec,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       flush,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ZERO = PW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Storage and control state.
  tdes_result_t      mem_r [DEPTH];
  logic [PW-1:0]     wrPtr_r;
  logic [PW-1:0]     rdPtr_r;
  logic [CW-1:0]     count_r;
  logic              overflow_r;
  logic              underflow_r;

  // Decoded per-cycle events.
  logic              full_s;
  logic              empty_s;
  logic              pushEn_s;
  logic              popEn_s;
  logic              dropPush_s;
  logic              badPop_s;
  logic [CW-1:0]     countNext_s;
  tdes_result_t      headEntry_s;

  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);

  // Decode push/pop acceptance and the error events for this cycle.
  always_comb begin
    pushEn_s   = 1'b0;
    popEn_s    = 1'b0;
    dropPush_s = 1'b0;
    badPop_s   = 1'b0;
    if (HRESET || flush) begin
      pushEn_s   = 1'b0;
      popEn_s    = 1'b0;
      dropPush_s = 1'b0;
      badPop_s   = 1'b0;
    end else begin
      // A full buffer still accepts a push when the head leaves the same cycle.
      pushEn_s   = in_valid & (~full_s | rd_pop);
      popEn_s    = rd_pop & ~empty_s;
      dropPush_s = in_valid & full_s & ~rd_pop;
      badPop_s   = rd_pop & empty_s;
    end
  end

  // Next occupancy: +1 on push only, -1 on pop only, unchanged otherwise.
  always_comb begin
    countNext_s = count_r;
    case ({pushEn_s, popEn_s})
      2'b10:   countNext_s = count_r + CNT_ONE;
      2'b01:   countNext_s = count_r - CNT_ONE;
      2'b11:   countNext_s = count_r;
      2'b00:   countNext_s = count_r;
      default: countNext_s = count_r;
    endcase
  end

  // Pointer, count and sticky flag registers; reset outranks flush.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wrPtr_r     <= PTR_ZERO;
      rdPtr_r     <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      wrPtr_r     <= PTR_ZERO;
      rdPtr_r     <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (pushEn_s) begin
        wrPtr_r <= wrPtr_r + PTR_ONE;
      end
      if (popEn_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      count_r <= countNext_s;
      if (dropPush_s) begin
        overflow_r <= 1'b1;
      end
      if (badPop_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge HCLK) begin
    if (pushEn_s) begin
      mem_r[wrPtr_r] <= packResult(in_encdec, in_data);
    end
  end

  // Show-ahead head: current entry, forced to zero while the buffer is empty.
  always_comb begin
    headEntry_s = '0;
    if (empty_s) begin
      headEntry_s = '0;
    end else begin
      headEntry_s = mem_r[rdPtr_r];
    end
  end

  assign rd_data   = headEntry_s.data;
  assign rd_encdec = headEntry_s.encdec;
  assign rd_valid  = ~empty_s;
  assign in_ready  = ~full_s;
  assign count     = count_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule : tdes_result_buffer

// File: tb/tb_tdes_result_buffer.sv
// Directed self-checking bench for tdes_result_buffer (DEPTH = 8).
module tb_tdes_result_buffer;

  logic        HCLK;
  logic        HRESET;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_encdec;
  logic        in_ready;
  logic        rd_pop;
  logic [63:0] rd_data;
  logic        rd_encdec;
  logic        rd_valid;
  logic [3:0]  count;
  logic        flush;
  logic        overflow;
  logic        underflow;

  int nCompared;
  int nMismatched;

  tdes_result_buffer #(.DEPTH(8), .DATA_W(64)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_encdec (in_encdec),
    .in_ready  (in_ready),
    .rd_pop    (rd_pop),
    .rd_data   (rd_data),
    .rd_encdec (rd_encdec),
    .rd_valid  (rd_valid),
    .count     (count),
    .flush     (flush),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic cyc(input logic v, input logic [63:0] d, input logic e,
                     input logic p, input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    in_encdec = e;
    rd_pop    = p;
    flush     = f;
    HRESET    = r;
    @(posedge HCLK);
    #1;
    in_valid  = 1'b0;
    in_data   = 64'h0;
    in_encdec = 1'b0;
    rd_pop    = 1'b0;
    flush     = 1'b0;
    HRESET    = 1'b0;
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "_count"},     64'(count),     64'd0);
    chk({tag, "_rd_valid"},  64'(rd_valid),  64'd0);
    chk({tag, "_rd_data"},   rd_data,        64'd0);
    chk({tag, "_rd_encdec"}, 64'(rd_encdec), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_overflow"},  64'(overflow),  64'd0);
    chk({tag, "_underflow"}, 64'(underflow), 64'd0);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    HRESET = 1'b1; in_valid = 1'b0; in_data = 64'h0; in_encdec = 1'b0;
    rd_pop = 1'b0; flush = 1'b0;

    // Reset
    cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chkIdle("reset");

    // Single push then pop
    cyc(1'b1, 64'h8fe0d9c6b3674857, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("single_valid",  64'(rd_valid),  64'd1);
    chk("single_data",   rd_data,        64'h8fe0d9c6b3674857);
    chk("single_encdec", 64'(rd_encdec), 64'd0);
    chk("single_count",  64'(count),     64'd1);
    cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("single_pop_valid", 64'(rd_valid), 64'd0);
    chk("single_pop_data",  rd_data,       64'd0);
    chk("single_pop_count", 64'(count),    64'd0);

    // Fill with 1..8, tag = LSB of the value
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 64'(i), i[0], 1'b0, 1'b0, 1'b0);
    end
    chk("fill_count",    64'(count),    64'd8);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      chk("pop3_head", rd_data, 64'(i));
      cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("pop3_count", 64'(count), 64'd5);
    for (int i = 9; i <= 11; i++) begin
      cyc(1'b1, 64'(i), i[0], 1'b0, 1'b0, 1'b0);
    end
    chk("wrap_count", 64'(count), 64'd8);
    for (int i = 4; i <= 11; i++) begin
      chk("order_data",   rd_data,        64'(i));
      chk("order_encdec", 64'(rd_encdec), 64'(i[0]));
      cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chkIdle("drained");

    // Full, push without pop: dropped
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 64'h11 + 64'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 64'hdeadbeefdeadbeef, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_flag",  64'(overflow), 64'd1);
    chk("ovf_count", 64'(count),    64'd8);
    chk("ovf_head",  rd_data,       64'h11);

    // Full, push and pop together: accepted, count holds
    cyc(1'b1, 64'h99, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count",    64'(count),    64'd8);
    chk("fullpp_in_ready", 64'(in_ready), 64'd0);
    chk("fullpp_head",     rd_data,       64'h12);
    for (int i = 0; i < 7; i++) begin
      chk("fullpp_order", rd_data, 64'h12 + 64'(i));
      cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("fullpp_last",        rd_data,        64'h99);
    chk("fullpp_last_encdec", 64'(rd_encdec), 64'd0);
    cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fullpp_empty",    64'(count),    64'd0);
    chk("ovf_sticky",      64'(overflow), 64'd1);

    // Empty pop: underflow; then pop + push while empty
    cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("udf_flag",  64'(underflow), 64'd1);
    chk("udf_count", 64'(count),     64'd0);
    cyc(1'b1, 64'h0ec42b5c22a87f17, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("udfpush_count",  64'(count),     64'd1);
    chk("udfpush_data",   rd_data,        64'h0ec42b5c22a87f17);
    chk("udfpush_encdec", 64'(rd_encdec), 64'd1);
    chk("udfpush_valid",  64'(rd_valid),  64'd1);

    // Flush with 5 entries and overflow set; push/pop in that cycle ignored
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 64'h50 + 64'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("preflush_count", 64'(count),    64'd5);
    chk("preflush_ovf",   64'(overflow), 64'd1);
    cyc(1'b1, 64'h77, 1'b1, 1'b1, 1'b1, 1'b0);
    chkIdle("flush");

    // Reset with 5 entries and overflow set, alongside push and pop
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 64'h60 + 64'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 64'h6f, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("prerst_count", 64'(count),    64'd5);
    chk("prerst_ovf",   64'(overflow), 64'd1);
    chk("prerst_head",  rd_data,       64'h63);
    cyc(1'b1, 64'h88, 1'b1, 1'b1, 1'b0, 1'b1);
    chkIdle("midrst");

    // Operation resumes normally after the mid-run reset
    cyc(1'b1, 64'hcafef00d12345678, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("postrst_data",  rd_data,    64'hcafef00d12345678);
    chk("postrst_count", 64'(count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule : tb_tdes_result_buffer
